// File: rtl/seg7_scan_capture_pkg.sv
// Shared constants for the seven-segment scan capture: glyph patterns, anode patterns,
// FSM encodings, digit slot indices and the BCD-to-binary helper.
package seg7_scan_capture_pkg;

  // Lit-segment patterns, bit6..0 = a,b,c,d,e,f,g (before display polarity)
  localparam logic [6:0] GLYPH_0     = 7'h7E;
  localparam logic [6:0] GLYPH_1     = 7'h30;
  localparam logic [6:0] GLYPH_2     = 7'h6D;
  localparam logic [6:0] GLYPH_3     = 7'h79;
  localparam logic [6:0] GLYPH_4     = 7'h33;
  localparam logic [6:0] GLYPH_5     = 7'h5B;
  localparam logic [6:0] GLYPH_6     = 7'h5F;
  localparam logic [6:0] GLYPH_7     = 7'h70;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h7B;
  localparam logic [6:0] GLYPH_9_ALT = 7'h73;

  localparam logic [3:0] AN_UNIT     = 4'b0111;
  localparam logic [3:0] AN_TEN      = 4'b1011;
  localparam logic [3:0] AN_HUNDRED  = 4'b1101;
  localparam logic [3:0] AN_THOUSAND = 4'b1110;
  localparam logic [3:0] AN_BLANK    = 4'b1111;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StHold   = 2'd2;

  localparam logic [1:0] SLOT_UNIT     = 2'd0;
  localparam logic [1:0] SLOT_TEN      = 2'd1;
  localparam logic [1:0] SLOT_HUNDRED  = 2'd2;
  localparam logic [1:0] SLOT_THOUSAND = 2'd3;

  function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
    logic [13:0] th, hu, te, un;
    th = {10'd0, bcd[15:12]};
    hu = {10'd0, bcd[11:8]};
    te = {10'd0, bcd[7:4]};
    un = {10'd0, bcd[3:0]};
    return th * 14'd1000 + hu * 14'd100 + te * 14'd10 + un;
  endfunction

endpackage

// File: rtl/seg7_scan_capture_glyph_decode.sv
// Combinational glyph decoder: 7-bit lit-segment pattern -> {valid, bcd}.
module seg7_scan_capture_glyph_decode
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0] lit_i,
  output logic       valid_o,
  output logic [3:0] bcd_o
);

  always_comb begin
    valid_o = 1'b1;
    bcd_o   = 4'd0;
    case (lit_i)
      GLYPH_0:              bcd_o = 4'd0;
      GLYPH_1:              bcd_o = 4'd1;
      GLYPH_2:              bcd_o = 4'd2;
      GLYPH_3:              bcd_o = 4'd3;
      GLYPH_4:              bcd_o = 4'd4;
      GLYPH_5:              bcd_o = 4'd5;
      GLYPH_6:              bcd_o = 4'd6;
      GLYPH_7:              bcd_o = 4'd7;
      GLYPH_8:              bcd_o = 4'd8;
      GLYPH_9, GLYPH_9_ALT: bcd_o = 4'd9;
      default:              valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Multiplexed 4-digit seven-segment bus reader: settles, decodes and frames digits into BCD/binary.
// Optional watchdog (stale_o) built when SCAN_WATCHDOG_EN is defined.
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned CNT_W          = 20
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  anode_select_i,
  input  logic [6:0]  seven_seg_i,
  output logic [15:0] digits_bcd_o,
  output logic [13:0] value_bin_o,
  output logic        frame_valid_o,
  output logic        code_err_o,
  output logic        anode_err_o,
  output logic        stale_o
);

  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);

  logic [3:0]       an_s1_q, an_s2_q, an_prev_q;
  logic [6:0]       seg_s1_q, seg_s2_q, seg_prev_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      shadow_q, shadow_d, digits_q, digits_d;
  logic [13:0]      value_q, value_d;
  logic [3:0]       mask_q, mask_d;
  logic             frame_q, frame_d, code_err_q, code_err_d, anode_err_q, anode_err_d;
  logic             chg, eval, slot_ok, glyph_valid, capture, wd_fire;
  logic [1:0]       slot;
  logic [3:0]       glyph_bcd;
  logic [6:0]       lit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_s1_q    <= AN_BLANK;
      an_s2_q    <= AN_BLANK;
      an_prev_q  <= AN_BLANK;
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      seg_prev_q <= '0;
    end else begin
      an_s1_q    <= anode_select_i;
      an_s2_q    <= an_s1_q;
      an_prev_q  <= an_s2_q;
      seg_s1_q   <= seven_seg_i;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
    end
  end

  assign chg = (an_s2_q != an_prev_q) || (seg_s2_q != seg_prev_q);
  assign lit = SEG_ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;

  seg7_scan_capture_glyph_decode u_glyph_decode (
    .lit_i   (lit),
    .valid_o (glyph_valid),
    .bcd_o   (glyph_bcd)
  );

  always_comb begin
    slot_ok = 1'b1;
    slot    = SLOT_UNIT;
    case (an_s2_q)
      AN_UNIT:     slot = SLOT_UNIT;
      AN_TEN:      slot = SLOT_TEN;
      AN_HUNDRED:  slot = SLOT_HUNDRED;
      AN_THOUSAND: slot = SLOT_THOUSAND;
      default:     slot_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eval    = 1'b0;
    case (state_q)
      StIdle: begin
        if (an_s2_q != AN_BLANK) begin
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        // A change always restarts settling, even on the cycle the limit is reached
        if (an_s2_q == AN_BLANK) begin
          state_d = StIdle;
        end else if (chg) begin
          cnt_d = '0;
        end else if (cnt_q == SettleLast) begin
          eval    = 1'b1;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHold: begin
        if (an_s2_q != an_prev_q) begin
          cnt_d   = '0;
          state_d = (an_s2_q == AN_BLANK) ? StIdle : StSettle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign capture     = eval && slot_ok && glyph_valid;
  assign anode_err_d = eval && !slot_ok;
  assign code_err_d  = eval && slot_ok && !glyph_valid;

  always_comb begin
    mask_d   = mask_q;
    shadow_d = shadow_q;
    digits_d = digits_q;
    value_d  = value_q;
    frame_d  = 1'b0;
    if (mask_q == 4'b1111) begin
      frame_d  = 1'b1;
      digits_d = shadow_q;
      value_d  = bcd_to_bin(shadow_q);
      mask_d   = '0;
    end
    if (wd_fire || code_err_d) begin
      mask_d = '0;
    end
    if (capture) begin
      shadow_d[{slot, 2'b00} +: 4] = glyph_bcd;
      mask_d[slot]                 = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shadow_q    <= '0;
      mask_q      <= '0;
      digits_q    <= '0;
      value_q     <= '0;
      frame_q     <= 1'b0;
      code_err_q  <= 1'b0;
      anode_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      mask_q      <= mask_d;
      digits_q    <= digits_d;
      value_q     <= value_d;
      frame_q     <= frame_d;
      code_err_q  <= code_err_d;
      anode_err_q <= anode_err_d;
    end
  end

`ifdef SCAN_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_q, wd_d;
  logic             stale_q, stale_d;

  // Counter saturates at the limit so the mask stays cleared until a capture rearms it
  always_comb begin
    wd_fire = !capture && (wd_q == TimeoutLast);
    wd_d    = capture ? '0 : (wd_fire ? wd_q : wd_q + CNT_W'(1));
    stale_d = capture ? 1'b0 : (wd_fire ? 1'b1 : stale_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q    <= '0;
      stale_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      stale_q <= stale_d;
    end
  end

  assign stale_o = stale_q;
`else
  assign wd_fire = 1'b0;
  assign stale_o = 1'b0;
`endif

  assign digits_bcd_o  = digits_q;
  assign value_bin_o   = value_q;
  assign frame_valid_o = frame_q;
  assign code_err_o    = code_err_q;
  assign anode_err_o   = anode_err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture: directed and randomized scans against a digit-level model.
module tb_seg7_scan_capture;

  localparam int unsigned SETTLE  = 20;
  localparam int unsigned TIMEOUT = 3000;
  localparam int          LONG    = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  anode = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] digits_bcd;
  logic [13:0] value_bin;
  logic        frame_valid, code_err, anode_err, stale;

  always #5 clk = ~clk;

  seg7_scan_capture #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .SEG_ACTIVE_LOW (1'b1),
    .CNT_W          (20)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .anode_select_i (anode),
    .seven_seg_i    (seg),
    .digits_bcd_o   (digits_bcd),
    .value_bin_o    (value_bin),
    .frame_valid_o  (frame_valid),
    .code_err_o     (code_err),
    .anode_err_o    (anode_err),
    .stale_o        (stale)
  );

  int checks = 0;
  int failures = 0;
  int fv_cnt = 0, ce_cnt = 0, ae_cnt = 0;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (code_err) ce_cnt++;
    if (anode_err) ae_cnt++;
  end

  // Digit-level reference model
  int m_digit[4];
  bit m_mask[4];
  int exp_val = 0, exp_bcd = 0, exp_frames = 0, exp_ce = 0, exp_ae = 0;
  bit exp_stale = 1'b0;

  function automatic logic [6:0] lit_of(int d, bit alt9);
    case (d)
      0: return 7'h7E;
      1: return 7'h30;
      2: return 7'h6D;
      3: return 7'h79;
      4: return 7'h33;
      5: return 7'h5B;
      6: return 7'h5F;
      7: return 7'h70;
      8: return 7'h7F;
      9: return alt9 ? 7'h73 : 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [3:0] an_of(int slot);
    case (slot)
      0: return 4'b0111;
      1: return 4'b1011;
      2: return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_mask[i] = 1'b0;
  endtask

  task automatic model_capture(input int slot, input int d);
    m_digit[slot] = d;
    m_mask[slot]  = 1'b1;
    exp_stale     = 1'b0;
    if (m_mask[0] && m_mask[1] && m_mask[2] && m_mask[3]) begin
      exp_val = m_digit[3] * 1000 + m_digit[2] * 100 + m_digit[1] * 10 + m_digit[0];
      exp_bcd = m_digit[3] * 4096 + m_digit[2] * 256 + m_digit[1] * 16 + m_digit[0];
      exp_frames++;
      model_clear();
    end
  endtask

  task automatic show(input int slot, input int d, input int dwell);
    anode = an_of(slot);
    seg   = ~lit_of(d, 1'($urandom_range(1)));
    cyc(dwell);
    if (dwell >= LONG) model_capture(slot, d);
  endtask

  task automatic show_bad(input int slot, input logic [6:0] s);
    anode = an_of(slot);
    seg   = s;
    cyc(LONG);
    exp_ce++;
    model_clear();
  endtask

  task automatic blank(input int n);
    anode = 4'hF;
    cyc(n);
  endtask

  task automatic scan(input int v);
    show(3, v / 1000, LONG);
    show(2, (v / 100) % 10, LONG);
    show(1, (v / 10) % 10, LONG);
    show(0, v % 10, LONG);
    blank(6);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_val"}, 32'(value_bin), exp_val);
    check({tag, "_bcd"}, 32'(digits_bcd), exp_bcd);
    check({tag, "_frames"}, fv_cnt, exp_frames);
    check({tag, "_codeerr"}, ce_cnt, exp_ce);
    check({tag, "_anodeerr"}, ae_cnt, exp_ae);
    check({tag, "_stale"}, 32'(stale), 32'(exp_stale));
  endtask

  initial begin
    int v;
    int order[4];
    model_clear();
    cyc(3);
    check_all("reset");
    rst_n = 1'b1;
    cyc(2);

    // Reset mid-frame discards partial digits
    show(3, 5, LONG);
    show(2, 6, LONG);
    anode = 4'hF;
    rst_n = 1'b0;
    cyc(2);
    model_clear();
    exp_val = 0;
    exp_bcd = 0;
    exp_stale = 1'b0;
    check_all("midreset");
    rst_n = 1'b1;
    cyc(3);
    scan(5678);
    check_all("after_reset_5678");

    scan(1234);
    check_all("scan_1234");
    scan(9999);
    check_all("scan_9999");
    scan(0);
    check_all("scan_0000");

    // Random values, random slot order, optional glitches and blank gaps
    for (int it = 0; it < 6; it++) begin
      v = int'($urandom_range(9999));
      for (int i = 0; i < 4; i++) order[i] = i;
      for (int i = 3; i > 0; i--) begin
        int j, t;
        j = int'($urandom_range(i));
        t = order[i];
        order[i] = order[j];
        order[j] = t;
      end
      for (int i = 0; i < 4; i++) begin
        int s, d;
        s = order[i];
        d = (s == 3) ? v / 1000 : (s == 2) ? (v / 100) % 10 : (s == 1) ? (v / 10) % 10 : v % 10;
        if ($urandom_range(1) == 1) show(s, (d + 1) % 10, 5);
        show(s, d, LONG + int'($urandom_range(10)));
        if ($urandom_range(1) == 1) blank(int'($urandom_range(1, 4)));
      end
      blank(6);
      check_all("random");
    end

    // Dwell shorter than the settle window: nothing captured
    show(3, 4, 10);
    show(2, 3, 10);
    show(1, 2, 10);
    show(0, 1, 10);
    blank(6);
    check_all("short_dwell");

    // Dark glyph on tens clears the partial frame
    show(3, 7, LONG);
    show(2, 8, LONG);
    show_bad(1, 7'h7F);
    show(0, 1, LONG);
    blank(6);
    check_all("bad_glyph");
    scan(7891);
    check_all("rescan_7891");

    // Bad anode pattern, then long blank for the watchdog
    show(3, 1, LONG);
    show(2, 2, LONG);
    anode = 4'b0011;
    seg = ~lit_of(5, 1'b0);
    cyc(LONG);
    exp_ae++;
    blank(int'(TIMEOUT) + 100);
`ifdef SCAN_WATCHDOG_EN
    exp_stale = 1'b1;
    model_clear();
`endif
    check_all("timeout");
    show(1, 3, LONG);
    show(0, 4, LONG);
    blank(6);
    check_all("after_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
